// File: rtl/hog_cell_feeder_pkg.sv
// Shared constants and packing-index helper for the HOG cell feeder and its checkers.
package hog_cell_feeder_pkg;

  localparam int PIX_W_DEF  = 8;
  localparam int CELL_S_DEF = 10;
  localparam int PIX_N_DEF  = CELL_S_DEF * CELL_S_DEF - 4;
  localparam int ROW_W_DEF  = PIX_W_DEF * CELL_S_DEF;
  localparam int IN_W_DEF   = PIX_W_DEF * PIX_N_DEF;

  // Packed pixel index of padded-cell pixel (r,c); -1 for the four dropped corners.
  function automatic int pack_idx(input int cs, input int r, input int c);
    bit edge_row;
    bit edge_col;
    edge_row = (r == 0) || (r == cs - 1);
    edge_col = (c == 0) || (c == cs - 1);
    if (edge_row && edge_col)
      return -1;
    else if (r == 0)
      return c - 1;
    else if (r == cs - 1)
      return (cs - 2) + cs * (cs - 2) + c - 1;
    else
      return (cs - 2) + cs * (r - 1) + c;
  endfunction

endpackage

// File: rtl/hog_cell_feeder_pack.sv
// Combinational row-to-bank-slice mapper: places every pixel of a row beat at its
// packed position and flags which packed pixels belong to the current row.
module hog_cell_pack
  import hog_cell_feeder_pkg::*;
#(
  parameter int PIX_W  = PIX_W_DEF,
  parameter int CELL_S = CELL_S_DEF
) (
  input  logic [$clog2(CELL_S)-1:0]         row,
  input  logic [PIX_W*CELL_S-1:0]           row_data,
  output logic [PIX_W*(CELL_S*CELL_S-4)-1:0] slice,
  output logic [CELL_S*CELL_S-5:0]          mask
);

  localparam int RW = $clog2(CELL_S);

  for (genvar r = 0; r < CELL_S; r++) begin : g_r
    for (genvar c = 0; c < CELL_S; c++) begin : g_c
      localparam int K = pack_idx(CELL_S, r, c);
      // Corner positions have no packed slot and simply fall away here.
      if (K >= 0) begin : g_pix
        assign slice[K*PIX_W +: PIX_W] = row_data[c*PIX_W +: PIX_W];
        assign mask[K] = (row == RW'(r));
      end
    end
  end

endmodule

// File: rtl/hog_cell_feeder.sv
// Ping-pong cell buffer feeding hog_svm: packs padded row beats into one word per cell.
// Optional statistics counters enabled by defining HOG_CELL_FEEDER_STAT_EN.
module hog_cell_feeder
  import hog_cell_feeder_pkg::*;
#(
  parameter int PIX_W  = PIX_W_DEF,
  parameter int CELL_S = CELL_S_DEF
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                i_valid,
  input  logic                                i_sof,
  input  logic [PIX_W*CELL_S-1:0]             i_data,
  output logic                                in_ready,
  output logic                                ready,
  input  logic                                request,
  output logic [PIX_W*(CELL_S*CELL_S-4)-1:0]  o_data
`ifdef HOG_CELL_FEEDER_STAT_EN
  ,
  output logic [15:0]                         cell_cnt,
  output logic [7:0]                          drop_cnt
`endif
);

  localparam int PIX_N = CELL_S * CELL_S - 4;
  localparam int IN_W  = PIX_W * PIX_N;
  localparam int RW    = $clog2(CELL_S);

  logic [RW-1:0]    row;
  logic [RW-1:0]    eff_row;
  logic [1:0]       valid;
  logic             wr_bank;
  logic             rd_bank;
  logic             accept;
  logic             done;
  logic             pop;
  logic [IN_W-1:0]  bank0;
  logic [IN_W-1:0]  bank1;
  logic [IN_W-1:0]  slice;
  logic [PIX_N-1:0] mask;

  assign in_ready = !valid[wr_bank];
  assign accept   = i_valid && in_ready;
  // A start-of-frame beat is always row 0, whatever the counter says.
  assign eff_row  = i_sof ? '0 : row;
  assign done     = accept && (eff_row == RW'(CELL_S - 1));
  assign pop      = request && valid[rd_bank];
  assign ready    = valid[rd_bank];
  assign o_data   = rd_bank ? bank1 : bank0;

  hog_cell_pack #(
    .PIX_W  (PIX_W),
    .CELL_S (CELL_S)
  ) u_pack (
    .row      (eff_row),
    .row_data (i_data),
    .slice    (slice),
    .mask     (mask)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid   <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      row     <= '0;
    end else begin
      if (accept)
        row <= done ? '0 : eff_row + RW'(1);
      if (done) begin
        valid[wr_bank] <= 1'b1;
        wr_bank        <= !wr_bank;
      end
      // A pop always targets the other bank from a completing write.
      if (pop) begin
        valid[rd_bank] <= 1'b0;
        rd_bank        <= !rd_bank;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bank0 <= '0;
      bank1 <= '0;
    end else if (accept) begin
      for (int k = 0; k < PIX_N; k++) begin
        if (mask[k]) begin
          if (wr_bank)
            bank1[k*PIX_W +: PIX_W] <= slice[k*PIX_W +: PIX_W];
          else
            bank0[k*PIX_W +: PIX_W] <= slice[k*PIX_W +: PIX_W];
        end
      end
    end
  end

`ifdef HOG_CELL_FEEDER_STAT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cell_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      if (done && (cell_cnt != '1))
        cell_cnt <= cell_cnt + 16'd1;
      if (accept && i_sof && (row != '0) && (drop_cnt != '1))
        drop_cnt <= drop_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hog_cell_feeder.sv
// Scoreboard testbench for hog_cell_feeder: expected packed cells are queued as cells are sent.
module tb_hog_cell_feeder;

  localparam int PIX_W  = 8;
  localparam int CELL_S = 10;
  localparam int PIX_N  = CELL_S * CELL_S - 4;
  localparam int ROW_W  = PIX_W * CELL_S;
  localparam int IN_W   = PIX_W * PIX_N;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              i_valid = 1'b0;
  logic              i_sof = 1'b0;
  logic [ROW_W-1:0]  i_data = '0;
  logic              in_ready;
  logic              ready;
  logic              request = 1'b0;
  logic [IN_W-1:0]   o_data;
`ifdef HOG_CELL_FEEDER_STAT_EN
  logic [15:0]       cell_cnt;
  logic [7:0]        drop_cnt;
`endif

  int checks = 0;
  int failures = 0;
  logic [IN_W-1:0] sb_q[$];

  always #5 clk = ~clk;

  hog_cell_feeder dut (
    .clk      (clk),
    .rst      (rst),
    .i_valid  (i_valid),
    .i_sof    (i_sof),
    .i_data   (i_data),
    .in_ready (in_ready),
    .ready    (ready),
    .request  (request),
    .o_data   (o_data)
`ifdef HOG_CELL_FEEDER_STAT_EN
    ,
    .cell_cnt (cell_cnt),
    .drop_cnt (drop_cnt)
`endif
  );

  function automatic logic [7:0] pix(input int id, input int r, input int c);
    return 8'((id * 37 + r * 10 + c) & 255);
  endfunction

  // Independent model: walk the padded cell in raster order, skipping corners.
  function automatic logic [IN_W-1:0] exp_cell(input int id);
    logic [IN_W-1:0] w;
    int k;
    w = '0;
    k = 0;
    for (int r = 0; r < CELL_S; r++)
      for (int c = 0; c < CELL_S; c++) begin
        if ((r == 0 || r == CELL_S-1) && (c == 0 || c == CELL_S-1)) continue;
        w[k*PIX_W +: PIX_W] = pix(id, r, c);
        k++;
      end
    return w;
  endfunction

  // Called just after a negedge; returns just after the following negedge.
  task automatic send_beat(input int id, input int r, input bit sof);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!in_ready) begin
      failures++;
      $display("FAIL beat_timeout id=%0d row=%0d in_ready=%0b required=1", id, r, in_ready);
    end
    for (int c = 0; c < CELL_S; c++) i_data[c*PIX_W +: PIX_W] = pix(id, r, c);
    i_sof   = sof;
    i_valid = 1'b1;
    if (r == CELL_S-1) sb_q.push_back(exp_cell(id));
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    i_sof   = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_cell(input int id);
    for (int r = 0; r < CELL_S; r++) send_beat(id, r, r == 0);
  endtask

  task automatic pop_check(input string name);
    logic [IN_W-1:0] e;
    checks++;
    if (ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_ready got=%0b required=1", name, ready);
    end
    checks++;
    if (sb_q.size() == 0) begin
      failures++;
      $display("FAIL %s_sb_empty got=%0d required>0", name, sb_q.size());
    end else begin
      e = sb_q.pop_front();
      if (o_data !== e) begin
        failures++;
        $display("FAIL %s_data got=%h required=%h", name, o_data, e);
      end
    end
    request = 1'b1;
    @(posedge clk);
    #1;
    request = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (ready !== 1'b0 || in_ready !== 1'b1 || o_data !== '0) begin
      failures++;
      $display("FAIL reset_outputs got ready=%0b in_ready=%0b o_data_zero=%0b required 0/1/1",
               ready, in_ready, o_data == '0);
    end
`ifdef HOG_CELL_FEEDER_STAT_EN
    checks++;
    if (cell_cnt !== 16'd0 || drop_cnt !== 8'd0) begin
      failures++;
      $display("FAIL reset_stats got cell=%0d drop=%0d required 0/0", cell_cnt, drop_cnt);
    end
`endif
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_cell();
    for (int r = 0; r < CELL_S-1; r++) send_beat(0, r, r == 0);
    checks++;
    if (ready !== 1'b0) begin
      failures++;
      $display("FAIL single_early_ready got=%0b required=0", ready);
    end
    send_beat(0, CELL_S-1, 1'b0);
    checks++;
    if (ready !== 1'b1) begin
      failures++;
      $display("FAIL single_latency got=%0b required=1", ready);
    end
    checks++;
    if (o_data[0 +: 8] !== 8'd1 || o_data[8*8 +: 8] !== 8'd10 || o_data[95*8 +: 8] !== 8'd98) begin
      failures++;
      $display("FAIL single_pixels got k0=%0d k8=%0d k95=%0d required 1/10/98",
               o_data[0 +: 8], o_data[8*8 +: 8], o_data[95*8 +: 8]);
    end
    pop_check("single");
    checks++;
    if (ready !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL single_after_pop got ready=%0b in_ready=%0b required 0/1", ready, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    send_cell(1);
    send_cell(2);
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL b2b_full_in_ready got=%0b required=0", in_ready);
    end
    for (int c = 0; c < CELL_S; c++) i_data[c*PIX_W +: PIX_W] = pix(3, 0, c);
    i_sof   = 1'b1;
    i_valid = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || o_data !== sb_q[0]) begin
      failures++;
      $display("FAIL b2b_held got in_ready=%0b cell1_ok=%0b required 0/1", in_ready, o_data === sb_q[0]);
    end
    i_valid = 1'b0;
    i_sof   = 1'b0;
    pop_check("b2b_cell1");
    // Pop at posedge t; in_ready must be back one cycle later, cell 2 on the output.
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_in_ready_rise got=%0b required=1", in_ready);
    end
    send_cell(3);
    pop_check("b2b_cell2");
    pop_check("b2b_cell3");
  endtask

  task automatic test_stream();
    int pops;
    int budget;
    pops = 0;
    budget = 0;
    fork
      begin
        for (int id = 10; id < 18; id++) send_cell(id);
      end
      begin
        while (pops < 8 && budget < 2000) begin
          @(negedge clk);
          budget++;
          if (ready) begin
            logic [IN_W-1:0] e;
            checks++;
            if (sb_q.size() == 0) begin
              failures++;
              $display("FAIL stream_sb_empty pop=%0d got=0 required>0", pops);
            end else begin
              e = sb_q.pop_front();
              if (o_data !== e) begin
                failures++;
                $display("FAIL stream_data pop=%0d got=%h required=%h", pops, o_data, e);
              end
            end
            request = 1'b1;
            pops++;
            @(posedge clk);
            #1;
            request = 1'b0;
          end
        end
      end
    join
    checks++;
    if (pops != 8 || sb_q.size() != 0 || ready !== 1'b0) begin
      failures++;
      $display("FAIL stream_count got pops=%0d left=%0d ready=%0b required 8/0/0", pops, sb_q.size(), ready);
    end
  endtask

  task automatic test_sof_abort();
    for (int r = 0; r < 5; r++) send_beat(20, r, r == 0);
    send_beat(21, 0, 1'b1);
    for (int r = 1; r < CELL_S-1; r++) send_beat(21, r, 1'b0);
    checks++;
    if (ready !== 1'b0) begin
      failures++;
      $display("FAIL sof_early_ready got=%0b required=0", ready);
    end
    send_beat(21, CELL_S-1, 1'b0);
`ifdef HOG_CELL_FEEDER_STAT_EN
    checks++;
    if (drop_cnt !== 8'd1) begin
      failures++;
      $display("FAIL sof_drop_cnt got=%0d required=1", drop_cnt);
    end
`endif
    pop_check("sof");
  endtask

  task automatic test_idle_request();
    request = 1'b1;
    repeat (3) @(negedge clk);
    request = 1'b0;
    @(negedge clk);
    checks++;
    if (ready !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL idle_req_state got ready=%0b in_ready=%0b required 0/1", ready, in_ready);
    end
    send_cell(30);
    pop_check("idle_req");
  endtask

  task automatic test_reset_mid();
    send_cell(40);
    pop_check("rmid_first");
    send_cell(41);
    for (int r = 0; r < 4; r++) send_beat(42, r, r == 0);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (ready !== 1'b0 || in_ready !== 1'b1 || o_data !== '0) begin
      failures++;
      $display("FAIL rmid_async got ready=%0b in_ready=%0b o_data_zero=%0b required 0/1/1",
               ready, in_ready, o_data == '0);
    end
    sb_q.delete();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    send_cell(43);
`ifdef HOG_CELL_FEEDER_STAT_EN
    checks++;
    if (cell_cnt !== 16'd1) begin
      failures++;
      $display("FAIL rmid_cell_cnt got=%0d required=1", cell_cnt);
    end
`endif
    pop_check("rmid_fresh");
  endtask

  initial begin
    test_reset();
    test_single_cell();
    test_back_to_back();
    test_stream();
    test_sof_abort();
    test_idle_request();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
